// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared types for the tank game bullet engine.
//   dir_t          bullet / fire direction encoding (matches the fire_dir pins)
//   bullet_slot_t  default-width (10-bit coordinate) view of one bullet_state
//                  slot, for consumers such as the renderer
//   slot_*         field offsets inside one packed slot for a given coordinate
//                  width: {active, dir[1:0], x, y}, with y in the low bits
// -----------------------------------------------------------------------------
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int DEFAULT_COORD_W = 10;

    typedef struct packed {
        logic                       active;
        dir_t                       dir;
        logic [DEFAULT_COORD_W-1:0] x;
        logic [DEFAULT_COORD_W-1:0] y;
    } bullet_slot_t;

    localparam int SLOT_Y_LSB = 0;

    function automatic int slot_width(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    function automatic int slot_active_bit(input int coord_w);
        return 2 * coord_w + 2;
    endfunction

    function automatic int slot_dir_lsb(input int coord_w);
        return 2 * coord_w;
    endfunction

    function automatic int slot_x_lsb(input int coord_w);
        return coord_w;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// -----------------------------------------------------------------------------
// bullet_slot
// One bullet slot register: loads on spawn, moves SPEED pixels per move tick,
// retires at the playfield edge (or wraps when BULLET_WRAP_EN is defined),
// and retires on a hit or a clear request.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   clear                 zero the slot next cycle (game over)
//   spawn                 load spawn_dir/spawn_x/spawn_y (only for idle slots)
//   tick                  shared move tick
//   hit_retire            slot hit an opposing tank; zero it next cycle
//   active, dir, x, y     registered slot contents
// Macro BULLET_WRAP_EN: defined -> toroidal wrap instead of edge retirement.
// -----------------------------------------------------------------------------
module bullet_slot
    import tank_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPEED    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               spawn,
    input  dir_t               spawn_dir,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               tick,
    input  logic               hit_retire,
    output logic               active,
    output dir_t               dir,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               edge_retire;

    // Bounds are tested before the subtract/add so nothing underflows.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        x_nxt       = x;
        y_nxt       = y;
        edge_retire = 1'b0;
        case (dir)
            DIR_UP: begin
                if (int'(y) < SPEED) begin
`ifdef BULLET_WRAP_EN
                    y_nxt = COORD_W'(int'(y) + SCREEN_H - SPEED);
`else
                    edge_retire = 1'b1;
`endif
                end else begin
                    y_nxt = COORD_W'(int'(y) - SPEED);
                end
            end
            DIR_DOWN: begin
                if (int'(y) + SPEED > SCREEN_H - 1) begin
`ifdef BULLET_WRAP_EN
                    y_nxt = COORD_W'(int'(y) + SPEED - SCREEN_H);
`else
                    edge_retire = 1'b1;
`endif
                end else begin
                    y_nxt = COORD_W'(int'(y) + SPEED);
                end
            end
            DIR_LEFT: begin
                if (int'(x) < SPEED) begin
`ifdef BULLET_WRAP_EN
                    x_nxt = COORD_W'(int'(x) + SCREEN_W - SPEED);
`else
                    edge_retire = 1'b1;
`endif
                end else begin
                    x_nxt = COORD_W'(int'(x) - SPEED);
                end
            end
            default: begin
                if (int'(x) + SPEED > SCREEN_W - 1) begin
`ifdef BULLET_WRAP_EN
                    x_nxt = COORD_W'(int'(x) + SPEED - SCREEN_W);
`else
                    edge_retire = 1'b1;
`endif
                end else begin
                    x_nxt = COORD_W'(int'(x) + SPEED);
                end
            end
        endcase
    end

    // Retirement of any kind zeroes the whole slot so the renderer sees a
    // clean all-zero entry. Retirement beats movement, movement beats spawn
    // (spawn only targets idle slots, so the two never collide).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all fields update together from
        // their pre-edge values; every field is reset, not just active.
        if (!reset_n || clear || hit_retire || (active && tick && edge_retire)) begin
            active <= 1'b0;
            dir    <= DIR_UP;
            x      <= '0;
            y      <= '0;
        end else if (active && tick) begin
            x <= x_nxt;
            y <= y_nxt;
        end else if (spawn) begin
            active <= 1'b1;
            dir    <= spawn_dir;
            x      <= spawn_x;
            y      <= spawn_y;
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// -----------------------------------------------------------------------------
// bullet_pool
// Multi-player bullet engine: NUM_PLAYERS shooters, MAX_BULLETS slots each.
// Holds fire edge detection, per-player cooldowns, the move-tick prescaler,
// the lowest-free-slot priority encoders and the hit OR-reduction; the slots
// themselves live in bullet_slot.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   game_over      clears all slots, blocks fire, freezes the prescaler
//   fire           per-player fire button (level; rising edge spawns)
//   fire_dir       per-player 2-bit direction (00 up, 01 down, 10 left, 11 right)
//   tank_x/tank_y  per-player tank position
//   hit            one-cycle pulse per player that was hit
//   fire_drop      one-cycle pulse per player whose spawn found the pool full
//   bullet_state   per slot {active, dir, x, y}; slot s of player p at
//                  index p*MAX_BULLETS+s
// Macro BULLET_WRAP_EN (in bullet_slot): wrap at screen edges instead of retiring.
// -----------------------------------------------------------------------------
module bullet_pool
    import tank_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_BULLETS = 8,
    parameter int COORD_W     = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int MOVE_TIME   = 250000,
    parameter int SPEED       = 2,
    parameter int COOLDOWN    = 1000000,
    parameter int HIT_R       = 8
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              game_over,
    input  logic [NUM_PLAYERS-1:0]                            fire,
    input  logic [NUM_PLAYERS*2-1:0]                          fire_dir,
    input  logic [NUM_PLAYERS*COORD_W-1:0]                    tank_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]                    tank_y,
    output logic [NUM_PLAYERS-1:0]                            hit,
    output logic [NUM_PLAYERS-1:0]                            fire_drop,
    output logic [NUM_PLAYERS*MAX_BULLETS*(2*COORD_W+3)-1:0]  bullet_state
);

    localparam int NS   = NUM_PLAYERS * MAX_BULLETS;
    localparam int SW   = slot_width(COORD_W);
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int PS_W = (MOVE_TIME > 1) ? $clog2(MOVE_TIME) : 1;

    logic [NUM_PLAYERS-1:0] fire_prev;
    logic [NUM_PLAYERS-1:0] fire_go;
    logic [NUM_PLAYERS-1:0] pool_full;
    logic [NUM_PLAYERS-1:0] hit_nxt;
    logic [CD_W-1:0]        cooldown [NUM_PLAYERS];
    logic [PS_W-1:0]        prescale;
    logic                   tick;

    logic [NS-1:0]          slot_active;
    logic [NS-1:0]          spawn_sel;
    logic [NS-1:0]          hit_retire;
    dir_t                   slot_dir [NS];
    logic [COORD_W-1:0]     slot_x   [NS];
    logic [COORD_W-1:0]     slot_y   [NS];

    assign tick = !game_over && (prescale == PS_W'(MOVE_TIME - 1));

    function automatic logic within_r(input logic [COORD_W-1:0] a,
                                      input logic [COORD_W-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = -d;
        return d < HIT_R;
    endfunction

    // A spawn is attempted on a rising fire edge outside cooldown and game over.
    // The free-slot search looks at pre-cycle active bits, so a slot retiring
    // this cycle only becomes reusable next cycle.
    always_comb begin
        fire_go   = '0;
        spawn_sel = '0;
        pool_full = '1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            fire_go[p] = fire[p] && !fire_prev[p] && (cooldown[p] == '0) && !game_over;
            for (int s = 0; s < MAX_BULLETS; s++) begin
                if (pool_full[p] && !slot_active[p*MAX_BULLETS+s]) begin
                    spawn_sel[p*MAX_BULLETS+s] = fire_go[p];
                    pool_full[p]               = 1'b0;
                end
            end
        end
    end

    // Any bullet of p inside the half-box of tank q (q != p) hits q and retires.
    always_comb begin
        hit_nxt    = '0;
        hit_retire = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int s = 0; s < MAX_BULLETS; s++) begin
                for (int q = 0; q < NUM_PLAYERS; q++) begin
                    if (q != p && slot_active[p*MAX_BULLETS+s]
                        && within_r(slot_x[p*MAX_BULLETS+s], tank_x[q*COORD_W +: COORD_W])
                        && within_r(slot_y[p*MAX_BULLETS+s], tank_y[q*COORD_W +: COORD_W])) begin
                        hit_nxt[q]                  = 1'b1;
                        hit_retire[p*MAX_BULLETS+s] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fire_prev <= '0;
            prescale  <= '0;
            hit       <= '0;
            fire_drop <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) cooldown[p] <= '0;
        end else begin
            fire_prev <= fire;
            hit       <= game_over ? '0 : hit_nxt;
            fire_drop <= fire_go & pool_full;
            if (!game_over) prescale <= tick ? '0 : prescale + 1'b1;
            // A refused (pool-full) spawn does not start a cooldown.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (fire_go[p] && !pool_full[p])
                    cooldown[p] <= CD_W'(COOLDOWN - 1);
                else if (cooldown[p] != '0)
                    cooldown[p] <= cooldown[p] - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NS; i++) begin : g_slot
        localparam int P = i / MAX_BULLETS;

        bullet_slot #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H),
            .SPEED    (SPEED)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear      (game_over),
            .spawn      (spawn_sel[i]),
            .spawn_dir  (dir_t'(fire_dir[P*2 +: 2])),
            .spawn_x    (tank_x[P*COORD_W +: COORD_W]),
            .spawn_y    (tank_y[P*COORD_W +: COORD_W]),
            .tick       (tick),
            .hit_retire (hit_retire[i]),
            .active     (slot_active[i]),
            .dir        (slot_dir[i]),
            .x          (slot_x[i]),
            .y          (slot_y[i])
        );

        assign bullet_state[i*SW + slot_active_bit(COORD_W)]          = slot_active[i];
        assign bullet_state[i*SW + slot_dir_lsb(COORD_W) +: 2]        = slot_dir[i];
        assign bullet_state[i*SW + slot_x_lsb(COORD_W)   +: COORD_W]  = slot_x[i];
        assign bullet_state[i*SW + SLOT_Y_LSB            +: COORD_W]  = slot_y[i];
    end

endmodule

// File: tb/tb_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_bullet_pool
// Self-checking bench for bullet_pool. A behavioural model predicts the
// outputs of every clock; predictions are queued before the edge and popped
// and compared after it. Directed spot checks cover the documented scenarios.
// Macro BULLET_WRAP_EN selects the wrap-mode expectations.
// -----------------------------------------------------------------------------
module tb_bullet_pool;

    localparam int NP    = 2;
    localparam int MB    = 2;
    localparam int CW    = 10;
    localparam int SWD   = 2 * CW + 3;
    localparam int TOT   = NP * MB * SWD;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int MT    = 5;
    localparam int SPD   = 1;
    localparam int CD    = 4;
    localparam int HR    = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             game_over;
    logic [NP-1:0]    fire;
    logic [2*NP-1:0]  fire_dir;
    logic [NP*CW-1:0] tank_x;
    logic [NP*CW-1:0] tank_y;
    logic [NP-1:0]    hit;
    logic [NP-1:0]    fire_drop;
    logic [TOT-1:0]   bullet_state;

    always #5 clk = ~clk;

    bullet_pool #(
        .NUM_PLAYERS (NP),
        .MAX_BULLETS (MB),
        .COORD_W     (CW),
        .SCREEN_W    (SCR_W),
        .SCREEN_H    (SCR_H),
        .MOVE_TIME   (MT),
        .SPEED       (SPD),
        .COOLDOWN    (CD),
        .HIT_R       (HR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .game_over    (game_over),
        .fire         (fire),
        .fire_dir     (fire_dir),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .hit          (hit),
        .fire_drop    (fire_drop),
        .bullet_state (bullet_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_act [NP][MB];
    int m_dir [NP][MB];
    int m_x   [NP][MB];
    int m_y   [NP][MB];
    int m_cd  [NP];
    int m_prev[NP];
    int m_pre;
    logic [NP-1:0] m_hit;
    logic [NP-1:0] m_drop;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_update();
        int n_act [NP][MB];
        int n_dir [NP][MB];
        int n_x   [NP][MB];
        int n_y   [NP][MB];
        int n_cd  [NP];
        int spawn_s[NP];
        bit ret   [NP][MB];
        logic [NP-1:0] h;
        logic [NP-1:0] d;
        bit tk;
        int nx, ny, free_s;
        if (!reset_n) begin
            for (int p = 0; p < NP; p++) begin
                for (int s = 0; s < MB; s++) begin
                    m_act[p][s] = 0; m_dir[p][s] = 0; m_x[p][s] = 0; m_y[p][s] = 0;
                end
                m_cd[p] = 0; m_prev[p] = 0;
            end
            m_pre = 0; m_hit = '0; m_drop = '0;
            return;
        end
        n_act = m_act; n_dir = m_dir; n_x = m_x; n_y = m_y; n_cd = m_cd;
        h = '0; d = '0;
        tk = !game_over && (m_pre == MT - 1);
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < MB; s++) begin
                ret[p][s] = 0;
                if (m_act[p][s] != 0)
                    for (int q = 0; q < NP; q++)
                        if (q != p
                            && iabs(m_x[p][s] - int'(tank_x[q*CW +: CW])) < HR
                            && iabs(m_y[p][s] - int'(tank_y[q*CW +: CW])) < HR) begin
                            h[q] = 1'b1;
                            ret[p][s] = 1;
                        end
            end
        for (int p = 0; p < NP; p++) begin
            spawn_s[p] = -1;
            free_s = -1;
            for (int s = MB - 1; s >= 0; s--) if (m_act[p][s] == 0) free_s = s;
            if (!game_over && fire[p] && m_prev[p] == 0 && m_cd[p] == 0) begin
                if (free_s >= 0) spawn_s[p] = free_s;
                else d[p] = 1'b1;
            end
            if (spawn_s[p] >= 0) n_cd[p] = CD - 1;
            else if (m_cd[p] > 0) n_cd[p] = m_cd[p] - 1;
        end
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < MB; s++) begin
                if (game_over || ret[p][s]) begin
                    n_act[p][s] = 0; n_dir[p][s] = 0; n_x[p][s] = 0; n_y[p][s] = 0;
                end else if (m_act[p][s] != 0 && tk) begin
                    nx = m_x[p][s]; ny = m_y[p][s];
                    case (m_dir[p][s])
                        0: ny = ny - SPD;
                        1: ny = ny + SPD;
                        2: nx = nx - SPD;
                        default: nx = nx + SPD;
                    endcase
                    if (nx < 0 || nx >= SCR_W || ny < 0 || ny >= SCR_H) begin
`ifdef BULLET_WRAP_EN
                        n_x[p][s] = (nx + SCR_W) % SCR_W;
                        n_y[p][s] = (ny + SCR_H) % SCR_H;
`else
                        n_act[p][s] = 0; n_dir[p][s] = 0; n_x[p][s] = 0; n_y[p][s] = 0;
`endif
                    end else begin
                        n_x[p][s] = nx; n_y[p][s] = ny;
                    end
                end else if (spawn_s[p] == s) begin
                    n_act[p][s] = 1;
                    n_dir[p][s] = int'(fire_dir[p*2 +: 2]);
                    n_x[p][s]   = int'(tank_x[p*CW +: CW]);
                    n_y[p][s]   = int'(tank_y[p*CW +: CW]);
                end
            end
        if (!game_over) m_pre = tk ? 0 : m_pre + 1;
        m_act = n_act; m_dir = n_dir; m_x = n_x; m_y = n_y; m_cd = n_cd;
        for (int p = 0; p < NP; p++) m_prev[p] = int'(fire[p]);
        m_hit  = game_over ? '0 : h;
        m_drop = d;
    endtask

    function automatic logic [TOT-1:0] model_state();
        logic [TOT-1:0] v;
        logic [SWD-1:0] sl;
        v = '0;
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < MB; s++) begin
                sl = {1'(m_act[p][s]), 2'(m_dir[p][s]), CW'(m_x[p][s]), CW'(m_y[p][s])};
                v[(p*MB+s)*SWD +: SWD] = sl;
            end
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [TOT-1:0] state;
        logic [NP-1:0]  hit;
        logic [NP-1:0]  drop;
    } exp_t;

    exp_t sb_q[$];

    task automatic step();
        exp_t e;
        model_update();
        e.state = model_state();
        e.hit   = m_hit;
        e.drop  = m_drop;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("state", bullet_state, e.state);
        check("hit",   hit,          e.hit);
        check("drop",  fire_drop,    e.drop);
    endtask

    // ---------------- DUT field helpers ----------------
    function automatic logic [SWD-1:0] slot_bits(input int p, input int s);
        return bullet_state[(p*MB+s)*SWD +: SWD];
    endfunction

    function automatic int slot_y(input int p, input int s);
        logic [SWD-1:0] b;
        b = slot_bits(p, s);
        return int'(b[CW-1:0]);
    endfunction

    function automatic int slot_x(input int p, input int s);
        logic [SWD-1:0] b;
        b = slot_bits(p, s);
        return int'(b[2*CW-1:CW]);
    endfunction

    function automatic int slot_act(input int p, input int s);
        logic [SWD-1:0] b;
        b = slot_bits(p, s);
        return int'(b[SWD-1]);
    endfunction

    function automatic int active_count(input int p);
        int c;
        c = 0;
        for (int s = 0; s < MB; s++) c += slot_act(p, s);
        return c;
    endfunction

    task automatic set_tank(input int p, input int x, input int y);
        tank_x[p*CW +: CW] = CW'(x);
        tank_y[p*CW +: CW] = CW'(y);
    endtask

    task automatic set_dir(input int p, input logic [1:0] d);
        fire_dir[p*2 +: 2] = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int last_x;
        bit seen0;

        reset_n = 1'b0; game_over = 1'b0; fire = '0; fire_dir = '0;
        tank_x = '0; tank_y = '0;
        set_tank(0, 100, 100);
        set_tank(1, 300, 300);
        step(); step();
        check("rst_state", bullet_state, '0);
        check("rst_hit", hit, '0);
        check("rst_drop", fire_drop, '0);
        reset_n = 1'b1;

        // Spawn and move: held fire gives exactly one bullet moving up 1 px per 5 cycles.
        set_dir(0, 2'b00);
        fire[0] = 1'b1;
        step();
        check("spawn_slot0", slot_bits(0, 0), {1'b1, 2'b00, 10'd100, 10'd100});
        n = 0;
        while (slot_y(0, 0) == 100 && n < 10) begin step(); n++; end
        check("first_tick_y", slot_y(0, 0), 99);
        repeat (5) step();
        check("second_tick_y", slot_y(0, 0), 98);
        check("held_fire_one", active_count(0), 1);
        fire[0] = 1'b0;

        // Top edge: retire (or wrap to the bottom row).
        n = 0;
        while (slot_y(0, 0) != 0 && n < 600) begin step(); n++; end
        check("reach_top", slot_y(0, 0), 0);
        n = 0;
        while (slot_act(0, 0) == 1 && slot_y(0, 0) == 0 && n < 10) begin step(); n++; end
`ifdef BULLET_WRAP_EN
        check("wrap_y", slot_y(0, 0), SCR_H - SPD);
        check("wrap_active", slot_act(0, 0), 1);
`else
        check("edge_retired", slot_act(0, 0), 0);
`endif
        game_over = 1'b1; step(); game_over = 1'b0;

        // Cooldown and pool-full.
        set_dir(0, 2'b01);
        fire[0] = 1'b1; step();
        check("cd_spawn1", active_count(0), 1);
        fire[0] = 1'b0; step();
        fire[0] = 1'b1; step();
        check("cd_ignored_drop", fire_drop, '0);
        check("cd_ignored_count", active_count(0), 1);
        fire[0] = 1'b0; repeat (4) step();
        fire[0] = 1'b1; step();
        check("cd_spawn2", active_count(0), 2);
        fire[0] = 1'b0; repeat (5) step();
        fire[0] = 1'b1; step();
        check("full_drop", fire_drop, 2'b01);
        check("full_count", active_count(0), 2);
        fire[0] = 1'b0; step();
        check("drop_once", fire_drop, '0);

        // game_over with three bullets in flight.
        set_dir(1, 2'b10);
        fire[1] = 1'b1; step();
        check("p1_spawn", active_count(1), 1);
        fire[1] = 1'b0; step();
        game_over = 1'b1; fire[1] = 1'b1; step();
        check("go_clear", bullet_state, '0);
        step();
        fire[1] = 1'b0; step();
        fire[1] = 1'b1; step();
        check("go_fire_ignored", bullet_state, '0);
        check("go_no_drop", fire_drop, '0);
        game_over = 1'b0; fire[1] = 1'b0; step();
        fire[1] = 1'b1; step();
        check("go_resume", active_count(1), 1);
        fire[1] = 1'b0;

        // Hit: p0 fires right at p1 ten pixels away.
        game_over = 1'b1; step(); game_over = 1'b0;
        set_tank(1, 110, 100);
        set_dir(0, 2'b11);
        fire[0] = 1'b1; step();
        fire[0] = 1'b0;
        check("hit_spawn", slot_bits(0, 0), {1'b1, 2'b11, 10'd100, 10'd100});
        n = 0; seen0 = 0; last_x = 0;
        while (hit == '0 && n < 50) begin
            last_x = slot_x(0, 0);
            step();
            if (hit[0]) seen0 = 1;
            n++;
        end
        check("hit_p1", hit, 2'b10);
        check("hit_at_x", last_x, 103);
        check("hit_freed", slot_act(0, 0), 0);
        step();
        if (hit[0]) seen0 = 1;
        check("hit_single", hit, '0);
        check("hit_own_never", seen0, 0);

        // Reset mid-flight.
        set_tank(1, 300, 300);
        fire[0] = 1'b1; step();
        fire[0] = 1'b0; repeat (3) step();
        check("pre_reset_count", active_count(0), 1);
        reset_n = 1'b0; step();
        check("rst2_state", bullet_state, '0);
        check("rst2_hit", hit, '0);
        check("rst2_drop", fire_drop, '0);
        reset_n = 1'b1; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
Multi-player bullet engine for the tank game. Successor to the single-shooter bullet block: NUM_PLAYERS shooters, each owning a fixed pool of bullet slots. Spawns bullets on fire edges with cooldown, moves them on a shared move tick, retires them at screen edges, and detects hits against every opposing tank. Sits between player-input/tank-position logic and the VGA renderer and score logic.

Parameters:
NUM_PLAYERS, 2, number of tanks/shooters (>=2)
MAX_BULLETS, 8, slots per player
COORD_W, 10, coordinate width (bits)
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
MOVE_TIME, 250000, clock cycles per move tick (>=1)
SPEED, 2, pixels moved per tick (>=1)
COOLDOWN, 1000000, minimum cycles between spawns of one player
HIT_R, 8, hit half-box in pixels

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
game_over  in  1  freeze/clear request
fire  in  NUM_PLAYERS  per-player fire button (level)
fire_dir  in  NUM_PLAYERS*2  per-player direction: 00 up, 01 down, 10 left, 11 right
tank_x  in  NUM_PLAYERS*COORD_W  per-player tank X
tank_y  in  NUM_PLAYERS*COORD_W  per-player tank Y
hit  out  NUM_PLAYERS  one-cycle pulse: player i was hit
fire_drop  out  NUM_PLAYERS  one-cycle pulse: spawn refused (pool full)
bullet_state  out  NUM_PLAYERS*MAX_BULLETS*(2*COORD_W+3)  per slot {active, dir[1:0], x, y}; slot s of player p at index p*MAX_BULLETS+s

Behaviour:
- Reset (reset_n low at a clk edge): all slots inactive, x/y/dir 0; hit, fire_drop 0; tick prescaler 0; cooldown counters 0; fire edge registers 0. Reset overrides everything, including mid-flight bullets.
- Fire: rising edge of fire[p] (registered previous value). Level-held fire spawns exactly one bullet.
- Spawn, edge sampled at cycle n: if cooldown[p]==0 and game_over==0, the lowest-index inactive slot of p becomes active at n+1 with x=tank_x[p], y=tank_y[p], dir=fire_dir[p]; cooldown[p] loads COOLDOWN-1 and decrements to 0. Edge during cooldown: ignored silently. Edge with pool full: no spawn, fire_drop[p] pulses at n+1, cooldown not loaded.
- Free-slot search uses pre-cycle state; a slot retired in cycle n is not reusable until n+1.
- Move tick: prescaler counts 0..MOVE_TIME-1; tick asserts one cycle at MOVE_TIME-1, then wraps to 0. On tick every active bullet moves SPEED px: up y-=SPEED, down y+=SPEED, left x-=SPEED, right x+=SPEED. A bullet spawned the same cycle does not move.
- Bounds: if the move would leave [0,SCREEN_W-1] x [0,SCREEN_H-1] (compare before subtract, no underflow), the slot goes inactive instead of moving.
- Hit: every cycle, an active bullet of p at (bx,by) hits tank q≠p when |bx-tank_x[q]|<HIT_R and |by-tank_y[q]|<HIT_R, using the post-move registered position. Slot is retired next cycle; hit[q] pulses once per cycle, OR of all hitting bullets. Own tank is never hit. One bullet overlapping two tanks hits both.
- game_over high: fire ignored, all slots cleared next cycle, hit/fire_drop held 0, prescaler holds. Deassertion resumes from cleared state.

Optional Feature:
Macro BULLET_WRAP_EN. Defined: bullets crossing an edge wrap toroidally (e.g. left from x<SPEED gives x+SCREEN_W-SPEED) and stay active; retirement only by hit or game_over. Undefined: edge retirement as above.

Decomposition:
Package tank_pkg: dir_t enum (DIR_UP/DOWN/LEFT/RIGHT), bullet_slot_t struct {active, dir, x, y}, and the bullet_state field offsets. Sub-module bullet_slot: one slot register with spawn load, move, bounds/wrap, and hit retirement. bullet_pool holds fire edge detection, cooldowns, prescaler, free-slot priority encoders, and the hit OR-reduction.

Test Plan:
- Spawn/move: MOVE_TIME=5, SPEED=1, p0 at (100,100), dir=00, fire held 10 cycles -> exactly one slot active at (100,100); y=99 after first tick, decrements by 1 every 5 cycles.
- Cooldown/full: COOLDOWN=4, MAX_BULLETS=2; three fire edges 6 cycles apart with no retirement -> slots 0,1 fill, third edge gives fire_drop[0] pulse; an edge 2 cycles after a spawn -> ignored, no drop.
- Edge retire: p0 bullet at y=1, dir=00, SPEED=2 -> slot inactive on next tick, no wrap. With BULLET_WRAP_EN -> y=479.
- Hit: p0 at (100,100) fires right, p1 at (110,100), HIT_R=8, SPEED=1 -> hit[1] single pulse when x reaches 103, slot freed next cycle, hit[0] never asserts.
- game_over mid-flight with 3 active bullets -> all inactive next cycle, fire edge during game_over ignored; resumes after deassert.
- reset_n low for one cycle mid-flight -> all outputs and slots zero next cycle.
